load_store_unit: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM pipeline register and Data_Memory.

---
 rtl/load_store_unit_if.sv | 25 ++
 rtl/load_store_unit.sv | 71 +++++++
 tb/tb_load_store_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline-side request/response and Data_Memory port bundle for the load/store unit
//  master: EX/MEM pipeline + Data_Memory side (drives requests and MEM_RDATA)
//  slave : load_store_unit (drives RDATA/BUSY/ERR and the memory write port)
interface load_store_unit_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [2:0]  FUNCT3;
  logic [31:0] ADDR;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        BUSY;
  logic        ERR;
  logic        MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA;
  modport master (
    output MEM_READ, MEM_WRITE, FUNCT3, ADDR, WDATA, MEM_RDATA,
    input  RDATA, BUSY, ERR, MEM_WE, MEM_ADDR, MEM_WDATA
  );
  modport slave (
    input  MEM_READ, MEM_WRITE, FUNCT3, ADDR, WDATA, MEM_RDATA,
    output RDATA, BUSY, ERR, MEM_WE, MEM_ADDR, MEM_WDATA
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 byte/half/word loads and stores onto a word-indexed memory, SB/SH as read-modify-write
//  CLK   : clock, rising edge
//  RESET : synchronous, active-low
//  bus   : request (MEM_READ/MEM_WRITE/FUNCT3/ADDR/WDATA), response (RDATA/BUSY/ERR),
//          memory port (MEM_WE/MEM_ADDR/MEM_WDATA out, MEM_RDATA in)
module load_store_unit #(
  parameter int AW = 10
) (
  input logic               CLK,
  input logic               RESET,
  load_store_unit_if.slave  bus
);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] RMW_WR = 1'b1;
  logic [0:0]    state;
  logic [31:0]   old_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [15:0]   wd_q;
  logic          sz_q;
  logic          idle, is_h, is_w, err_c, sw, sbh;
  logic [7:0]    byt;
  logic [15:0]   half;
  logic [31:0]   ld, mask, merged;
  logic          unused_ok;
  // upper address bits wrap by design
  assign unused_ok = ^bus.ADDR[31:AW+2];
  always_comb begin
    idle   = RESET && state == IDLE;
    is_h   = bus.FUNCT3[1:0] == 2'b01;
    is_w   = bus.FUNCT3 == 3'b010;
    err_c  = idle && ((bus.MEM_READ && bus.MEM_WRITE)
          || ((bus.MEM_READ || bus.MEM_WRITE) && ((is_h && bus.ADDR[0]) || (is_w && bus.ADDR[1:0] != 2'b00)))
          || (bus.MEM_WRITE && (bus.FUNCT3[2] || bus.FUNCT3 == 3'b011))
          || (bus.MEM_READ && (bus.FUNCT3 == 3'b011 || bus.FUNCT3[2:1] == 2'b11)));
    sw     = idle && bus.MEM_WRITE && is_w && !err_c;
    sbh    = idle && bus.MEM_WRITE && !is_w && !err_c;
    byt    = bus.MEM_RDATA[{bus.ADDR[1:0], 3'b000} +: 8];
    half   = bus.ADDR[1] ? bus.MEM_RDATA[31:16] : bus.MEM_RDATA[15:0];
    // FUNCT3[2] selects zero-extension (BU/HU)
    ld     = bus.FUNCT3[1:0] == 2'b00 ? {{24{byt[7] && !bus.FUNCT3[2]}}, byt}
           : is_h ? {{16{half[15] && !bus.FUNCT3[2]}}, half} : bus.MEM_RDATA;
    mask   = (sz_q ? 32'h0000_FFFF : 32'h0000_00FF) << {off_q, 3'b000};
    merged = (old_q & ~mask) | (({16'h0000, wd_q} << {off_q, 3'b000}) & mask);
    bus.RDATA     = idle && bus.MEM_READ && !err_c ? ld : 32'h0;
    bus.BUSY      = sbh;
    bus.ERR       = err_c;
    bus.MEM_WE    = sw || (RESET && state == RMW_WR);
    bus.MEM_ADDR  = {{(32-AW){1'b0}}, state == RMW_WR ? idx_q : bus.ADDR[AW+1:2]};
    bus.MEM_WDATA = state == RMW_WR ? merged : bus.WDATA;
  end
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
      old_q <= '0;
      idx_q <= '0;
      off_q <= '0;
      wd_q  <= '0;
      sz_q  <= 1'b0;
    end else if (state == RMW_WR) begin
      state <= IDLE;
    end else if (sbh) begin
      state <= RMW_WR;
      old_q <= bus.MEM_RDATA;
      idx_q <= bus.ADDR[AW+1:2];
      off_q <= bus.ADDR[1:0];
      wd_q  <= bus.WDATA[15:0];
      sz_q  <= bus.FUNCT3[0];
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors for load_store_unit against a word-indexed memory model
module tb_load_store_unit;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic preload = 1'b1;
  logic [31:0] mem [0:1023];
  int n_tests = 0;
  int n_fail = 0;
  load_store_unit_if b ();
  load_store_unit #(.AW(10)) dut (.CLK(CLK), .RESET(RESET), .bus(b));
  always #5 CLK = ~CLK;
  assign b.MEM_RDATA = mem[b.MEM_ADDR[9:0]];
  always @(posedge CLK) begin
    if (preload) begin
      mem[0] <= 32'h0000_0000;
      mem[1] <= 32'h0000_0056;
    end else if (b.MEM_WE) begin
      mem[b.MEM_ADDR[9:0]] <= b.MEM_WDATA;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    b.MEM_READ = rd;
    b.MEM_WRITE = wr;
    b.FUNCT3 = f3;
    b.ADDR = a;
    b.WDATA = wd;
    #2;
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp);
    req(1'b1, 1'b0, f3, a, 32'h0);
    chk(tag, b.RDATA, exp);
    chk({tag, "_err"}, {31'h0, b.ERR}, 32'h0);
    chk({tag, "_busy"}, {31'h0, b.BUSY}, 32'h0);
    step();
  endtask
  task automatic bad(input string tag, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    req(rd, wr, f3, a, 32'hCAFE_F00D);
    chk({tag, "_err"}, {31'h0, b.ERR}, 32'h1);
    chk({tag, "_we"}, {31'h0, b.MEM_WE}, 32'h0);
    chk({tag, "_busy"}, {31'h0, b.BUSY}, 32'h0);
    chk({tag, "_rdata"}, b.RDATA, 32'h0);
    step();
  endtask
  task automatic sub(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word);
    req(1'b0, 1'b1, f3, a, wd);
    chk({tag, "_busy"}, {31'h0, b.BUSY}, 32'h1);
    chk({tag, "_we0"}, {31'h0, b.MEM_WE}, 32'h0);
    step();
    #2;
    chk({tag, "_we1"}, {31'h0, b.MEM_WE}, 32'h1);
    chk({tag, "_wdata"}, b.MEM_WDATA, word);
    chk({tag, "_busy1"}, {31'h0, b.BUSY}, 32'h0);
    chk({tag, "_rd1"}, b.RDATA, 32'h0);
    step();
  endtask
  initial begin
    req(1'b1, 1'b1, 3'b000, 32'h5, 32'hFF);
    step();
    step();
    chk("rst_busy", {31'h0, b.BUSY}, 32'h0);
    chk("rst_we", {31'h0, b.MEM_WE}, 32'h0);
    chk("rst_err", {31'h0, b.ERR}, 32'h0);
    req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0);
    chk("rst_rdata", b.RDATA, 32'h0);
    preload = 1'b0;
    RESET = 1'b1;
    req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    step();
    load("t1_lb", 3'b000, 32'h4, 32'h0000_0056);
    load("t1_lbu", 3'b100, 32'h4, 32'h0000_0056);
    load("t1_lh", 3'b001, 32'h4, 32'h0000_0056);
    load("t1_lw", 3'b010, 32'h4, 32'h0000_0056);
    sub("t2_sb", 3'b000, 32'h5, 32'h1234_56FF, 32'h0000_FF56);
    load("t2_lb", 3'b000, 32'h5, 32'hFFFF_FFFF);
    load("t2_lbu", 3'b100, 32'h5, 32'h0000_00FF);
    sub("t3_sh", 3'b001, 32'h6, 32'h0000_8001, 32'h8001_FF56);
    load("t3_lh", 3'b001, 32'h6, 32'hFFFF_8001);
    load("t3_lhu", 3'b101, 32'h6, 32'h0000_8001);
    load("t3_lh_lo", 3'b001, 32'h4, 32'hFFFF_FF56);
    bad("t4_sw6", 1'b0, 1'b1, 3'b010, 32'h6);
    bad("t4_lw2", 1'b1, 1'b0, 3'b010, 32'h2);
    bad("t4_lh3", 1'b1, 1'b0, 3'b001, 32'h3);
    bad("t4_rdwr", 1'b1, 1'b1, 3'b010, 32'h4);
    bad("t4_st100", 1'b0, 1'b1, 3'b100, 32'h4);
    bad("t4_ld011", 1'b1, 1'b0, 3'b011, 32'h4);
    chk("t4_word1", mem[1], 32'h8001_FF56);
    req(1'b0, 1'b0, 3'b010, 32'h4, 32'h1);
    chk("nop_we", {31'h0, b.MEM_WE}, 32'h0);
    chk("nop_busy", {31'h0, b.BUSY}, 32'h0);
    chk("nop_err", {31'h0, b.ERR}, 32'h0);
    chk("nop_rdata", b.RDATA, 32'h0);
    step();
    req(1'b0, 1'b1, 3'b000, 32'h4, 32'h0000_00AA);
    chk("t5_busy", {31'h0, b.BUSY}, 32'h1);
    step();
    RESET = 1'b0;
    #2;
    chk("t5_we", {31'h0, b.MEM_WE}, 32'h0);
    chk("t5_busy_rst", {31'h0, b.BUSY}, 32'h0);
    step();
    RESET = 1'b1;
    load("t5_lw", 3'b010, 32'h4, 32'h8001_FF56);
    chk("t5_word1", mem[1], 32'h8001_FF56);
    req(1'b0, 1'b1, 3'b010, 32'h1000, 32'hDEAD_BEEF);
    chk("t6_sw_we", {31'h0, b.MEM_WE}, 32'h1);
    chk("t6_sw_addr", b.MEM_ADDR, 32'h0);
    chk("t6_sw_wdata", b.MEM_WDATA, 32'hDEAD_BEEF);
    chk("t6_sw_busy", {31'h0, b.BUSY}, 32'h0);
    step();
    chk("t6_word0", mem[0], 32'hDEAD_BEEF);
    load("t6_lw0", 3'b010, 32'h0, 32'hDEAD_BEEF);
    sub("t6_sb1", 3'b000, 32'h1, 32'h0000_0011, 32'hDEAD_11EF);
    sub("t6_sb2", 3'b000, 32'h2, 32'h0000_0022, 32'hDE22_11EF);
    load("t6_lw_merge", 3'b010, 32'h0, 32'hDE22_11EF);
    load("t6_wrap", 3'b010, 32'h1004, 32'h8001_FF56);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
